afe_cfg_ctrl: RTL and testbench
===============================

// Module: afe_cfg_ctrl
// PURPOSE
//  Bring-up and register-access sequencer for the AFE control interface (afe_reset, afe_sen, SPI, tx/rx enables).
//  On start: pulses afe_reset, waits for wake-up, writes an init register table over SPI, then releases afe_tx_en/afe_rx_en.
//  After init, serves single host (RPi-side) register read/write requests. Sits beside the afe datapath block in top.
// PARAMETERS
//  ADDR_WIDTH    7    AFE register address bits in the SPI frame
//  DATA_WIDTH    8    AFE register data bits in the SPI frame
//  SCLK_DIV      4    clk cycles per SPI clock half-period (>=2)
//  RESET_CYCLES  64   clk cycles afe_reset is held high
//  WAKE_CYCLES   256  clk cycles waited after afe_reset release before the first frame
//  INIT_LEN      4    number of init table entries (0 = skip table)
// PORTS
//  clk           in   1    system clock
//  reset         in   1    asynchronous, active-high reset
//  start         in   1    1-cycle pulse: run the bring-up sequence
//  init_done     out  1    high while in IDLE after a completed bring-up
//  busy          out  1    high in any state except IDLE/OFF
//  tbl_idx       out  8    init table index being fetched
//  tbl_word      in   ADDR_WIDTH+DATA_WIDTH  {addr,data} for tbl_idx (combinational ROM)
//  req_valid     in   1    host register access request
//  req_ready     out  1    request accepted when valid&ready
//  req_rw        in   1    1=read, 0=write
//  req_addr      in   ADDR_WIDTH  register address
//  req_wdata     in   DATA_WIDTH  write data
//  rsp_valid     out  1    1-cycle pulse: access finished
//  rsp_rdata     out  DATA_WIDTH  read data (held until next rsp_valid)
//  tx_en_req     in   1    host wants AFE TX enabled
//  rx_en_req     in   1    host wants AFE RX enabled
//  afe_reset     out  1    AFE hardware reset, active-high
//  afe_sen       out  1    SPI chip select, active-low
//  afe_spi_clk   out  1    SPI clock, idle low
//  afe_spi_mosi  out  1    SPI data to AFE
//  afe_spi_miso  in   1    SPI data from AFE
//  afe_tx_en     out  1    = tx_en_req & init_done, registered
//  afe_rx_en     out  1    = rx_en_req & init_done, registered
// BEHAVIOUR
//  Reset values: afe_reset=0, afe_sen=1, afe_spi_clk=0, afe_spi_mosi=0, afe_tx_en=afe_rx_en=0, init_done=0,
//   busy=0, req_ready=0, rsp_valid=0, rsp_rdata=0, tbl_idx=0; FSM in OFF. Reset mid-frame aborts immediately.
//  FSM: OFF -start-> RST_HOLD (afe_reset=1, RESET_CYCLES) -> RST_WAIT (afe_reset=0, WAKE_CYCLES)
//   -> INIT (one write frame per entry, tbl_idx 0..INIT_LEN-1; INIT_LEN=0 goes straight on) -> IDLE.
//   IDLE -req_valid-> XFER -> IDLE. IDLE -start-> RST_HOLD (re-bring-up; init_done drops same cycle).
//  start outside OFF/IDLE is ignored. In IDLE, start and req_valid together: start wins, req not accepted.
//  req_ready = (state==IDLE) & ~start. Request fields latched on the accept cycle.
//  Frame: 1+ADDR_WIDTH+DATA_WIDTH bits, MSB first, {rw, addr, data}; reads drive data bits 0 on mosi.
//   sen falls at cycle T with bit0 on mosi; sclk rises at T+(2k+1)*SCLK_DIV, falls at T+(2k+2)*SCLK_DIV;
//   mosi updates on each fall; miso sampled into shift reg on each rise (data-phase bits form rsp_rdata).
//   sen rises at T+(2N+1)*SCLK_DIV (N=frame bits); sen stays high >= 2*SCLK_DIV before next frame.
//  rsp_valid pulses on the cycle sen rises after an XFER frame (write or read); never for INIT frames.
//  Table fetch: tbl_idx stable for the whole frame; tbl_word sampled on the cycle sen falls.
//  afe_tx_en/afe_rx_en update 1 cycle after tx_en_req/rx_en_req/init_done change; forced 0 outside IDLE/XFER.
// TESTING
//  Reset, no start -> all outputs at reset values for 1000 cycles; sen=1, sclk=0.
//  start, INIT_LEN=2, table {0x05,0xA5},{0x7F,0x3C} -> afe_reset high 64 cyc, 256 idle, frames 0x05A5 then 0x7F3C, init_done=1.
//  Write req addr=0x12 data=0x5A -> mosi 0x125A MSB first, sclk period 8 clk, rsp_valid 132 cyc after sen fall.
//  Read req addr=0x33, AFE model returns 0xC3 -> mosi 0xB300, rsp_rdata=0xC3 with rsp_valid.
//  tx_en_req=rx_en_req=1 before init -> enables stay 0; after init_done -> both 1 one cycle later; start again -> both 0.
//  Assert reset mid-read frame -> sen=1, sclk=0 asynchronously; no rsp_valid; next start runs full bring-up.

Source files
------------

// File: rtl/afe_cfg_ctrl.sv
// AFE control sequencer: afe_reset pulse, wake-up wait, SPI init-table writes,
// then single host register read/write frames and gated tx/rx enables.
module afe_cfg_ctrl #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int SCLK_DIV     = 4,
  parameter int RESET_CYCLES = 64,
  parameter int WAKE_CYCLES  = 256,
  parameter int INIT_LEN     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             init_done,
  output logic                             busy,
  output logic [7:0]                       tbl_idx,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] tbl_word,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_rw,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  input  logic                             tx_en_req,
  input  logic                             rx_en_req,
  output logic                             afe_reset,
  output logic                             afe_sen,
  output logic                             afe_spi_clk,
  output logic                             afe_spi_mosi,
  input  logic                             afe_spi_miso,
  output logic                             afe_tx_en,
  output logic                             afe_rx_en
);

  localparam int FW   = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int HW   = $clog2(2*FW + 3);
  localparam int DVW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int WMAX = (RESET_CYCLES > WAKE_CYCLES) ? RESET_CYCLES : WAKE_CYCLES;
  localparam int CW   = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    ST_OFF, ST_RST_HOLD, ST_RST_WAIT, ST_INIT, ST_IDLE, ST_XFER
  } state_t;

  state_t          state;
  logic [CW-1:0]   wcnt;
  logic            fr_act;
  logic [DVW-1:0]  div;
  logic [HW-1:0]   hcnt;
  logic [FW-1:0]   tx;
  logic [DATA_WIDTH-1:0] rx;

  logic            tick, fr_done, wake_done, fr_start;
  logic [FW-1:0]   fr_word;

  assign tick      = fr_act && (div == DVW'(SCLK_DIV - 1));
  assign fr_done   = tick && (hcnt == HW'(2*FW + 2));
  assign wake_done = (state == ST_RST_WAIT) && (wcnt == CW'(WAKE_CYCLES - 1));
  assign busy      = (state != ST_IDLE) && (state != ST_OFF);
  assign req_ready = (state == ST_IDLE) && !start;

  // Frame launch: first init frame starts on the wake-up exit edge, later ones
  // one cycle after tbl_idx advances so the ROM output has settled.
  always_comb begin
    fr_start = 1'b0;
    fr_word  = '0;
    case (state)
      ST_RST_WAIT: if (wake_done && INIT_LEN != 0) begin
        fr_start = 1'b1;
        fr_word  = {1'b0, tbl_word};
      end
      ST_INIT: if (!fr_act) begin
        fr_start = 1'b1;
        fr_word  = {1'b0, tbl_word};
      end
      ST_IDLE: if (req_valid && !start) begin
        fr_start = 1'b1;
        fr_word  = {req_rw, req_addr, req_rw ? {DATA_WIDTH{1'b0}} : req_wdata};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_OFF;
      wcnt         <= '0;
      fr_act       <= 1'b0;
      div          <= '0;
      hcnt         <= '0;
      tx           <= '0;
      rx           <= '0;
      tbl_idx      <= '0;
      init_done    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      afe_reset    <= 1'b0;
      afe_sen      <= 1'b1;
      afe_spi_clk  <= 1'b0;
      afe_spi_mosi <= 1'b0;
      afe_tx_en    <= 1'b0;
      afe_rx_en    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      afe_tx_en <= tx_en_req & init_done;
      afe_rx_en <= rx_en_req & init_done;

      // hcnt counts SCLK half periods since sen fell: even->rise, odd->fall,
      // 2*FW -> sen rises, then two more halves of guaranteed sen-high gap.
      if (fr_start) begin
        fr_act       <= 1'b1;
        div          <= '0;
        hcnt         <= '0;
        afe_sen      <= 1'b0;
        afe_spi_clk  <= 1'b0;
        tx           <= fr_word;
        afe_spi_mosi <= fr_word[FW-1];
      end else if (fr_act) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) begin
          hcnt <= hcnt + 1'b1;
          if (hcnt < HW'(2*FW)) begin
            if (!hcnt[0]) begin
              afe_spi_clk <= 1'b1;
              rx          <= {rx[DATA_WIDTH-2:0], afe_spi_miso};
            end else begin
              afe_spi_clk  <= 1'b0;
              tx           <= tx << 1;
              afe_spi_mosi <= tx[FW-2];
            end
          end else if (hcnt == HW'(2*FW)) begin
            afe_sen      <= 1'b1;
            afe_spi_mosi <= 1'b0;
            if (state == ST_XFER) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= rx;
            end
          end
          if (fr_done) fr_act <= 1'b0;
        end
      end

      case (state)
        ST_OFF: if (start) begin
          state     <= ST_RST_HOLD;
          afe_reset <= 1'b1;
          wcnt      <= '0;
          tbl_idx   <= '0;
        end
        ST_RST_HOLD: if (wcnt == CW'(RESET_CYCLES - 1)) begin
          afe_reset <= 1'b0;
          wcnt      <= '0;
          state     <= ST_RST_WAIT;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        ST_RST_WAIT: if (wake_done) begin
          if (INIT_LEN == 0) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end else begin
            state <= ST_INIT;
          end
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        ST_INIT: if (fr_done) begin
          if (tbl_idx == 8'(INIT_LEN - 1)) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end else begin
            tbl_idx <= tbl_idx + 1'b1;
          end
        end
        ST_IDLE: if (start) begin
          state     <= ST_RST_HOLD;
          afe_reset <= 1'b1;
          wcnt      <= '0;
          tbl_idx   <= '0;
          init_done <= 1'b0;
        end else if (req_valid) begin
          state <= ST_XFER;
        end
        // init_done stays up through a register access so the tx/rx enables
        // do not glitch while the host talks to the AFE.
        ST_XFER: if (fr_done) state <= ST_IDLE;
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_afe_cfg_ctrl.sv
// Bench for afe_cfg_ctrl: SPI-slave AFE model with register file, reference
// register map, randomized host accesses, bring-up timing and abort checks.
module tb_afe_cfg_ctrl;
  localparam int AW = 7, DW = 8, DIV = 4, RC = 64, WC = 256, IL = 2;
  localparam int FB = 1 + AW + DW;

  logic clk = 0, reset = 1, start = 0;
  logic init_done, busy, req_ready, rsp_valid;
  logic [7:0] tbl_idx;
  logic [AW+DW-1:0] tbl_word;
  logic req_valid = 0, req_rw = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, rsp_rdata;
  logic tx_en_req = 0, rx_en_req = 0;
  logic afe_reset, afe_sen, afe_spi_clk, afe_spi_mosi, afe_tx_en, afe_rx_en;
  logic miso = 0;

  afe_cfg_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SCLK_DIV(DIV),
                 .RESET_CYCLES(RC), .WAKE_CYCLES(WC), .INIT_LEN(IL)) dut (
    .clk(clk), .reset(reset), .start(start), .init_done(init_done), .busy(busy),
    .tbl_idx(tbl_idx), .tbl_word(tbl_word), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .tx_en_req(tx_en_req), .rx_en_req(rx_en_req),
    .afe_reset(afe_reset), .afe_sen(afe_sen), .afe_spi_clk(afe_spi_clk),
    .afe_spi_mosi(afe_spi_mosi), .afe_spi_miso(miso), .afe_tx_en(afe_tx_en),
    .afe_rx_en(afe_rx_en));

  always #5 clk = ~clk;

  always_comb begin
    case (tbl_idx)
      8'd0:    tbl_word = {7'h05, 8'hA5};
      8'd1:    tbl_word = {7'h7F, 8'h3C};
      default: tbl_word = '0;
    endcase
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // AFE model: captures frames on sclk rise, serves read data on sclk fall.
  logic [DW-1:0] afe_mem [128];
  logic [DW-1:0] ref_mem [128];
  logic [FB-1:0] frames [$];
  logic [FB-1:0] a_sh = '0;
  logic [AW-1:0] a_addr = '0;
  int a_bits = 0;

  always @(negedge afe_sen) begin a_bits = 0; a_sh = '0; miso = 0; end
  always @(posedge afe_spi_clk) if (!afe_sen) begin
    a_sh = {a_sh[FB-2:0], afe_spi_mosi};
    a_bits++;
    if (a_bits == 1 + AW) a_addr = a_sh[AW-1:0];
  end
  always @(negedge afe_spi_clk) if (!afe_sen && a_bits >= 1 + AW && a_bits < FB)
    miso = afe_mem[a_addr][FB-1-a_bits];
  always @(posedge afe_sen) begin
    if (a_bits == FB) begin
      frames.push_back(a_sh);
      if (!a_sh[FB-1]) afe_mem[a_sh[FB-2:DW]] = a_sh[DW-1:0];
    end
    a_bits = 0;
  end

  // Cycle-level monitor: SCLK timing, rsp pulses, enables forced off.
  int cyc = 0, fall_cyc = 0, last_rise = -1, sclk_viol = 0, en_viol = 0, n_rsp = 0;
  logic p_sen = 1, p_clk = 0, p_init = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin : mon
    int e;
    if (p_sen && !afe_sen) begin fall_cyc = cyc; last_rise = -1; end
    if (!p_clk && afe_spi_clk) begin
      e = (last_rise < 0) ? fall_cyc + DIV : last_rise + 2*DIV;
      if (cyc != e) sclk_viol++;
      last_rise = cyc;
    end
    if (rsp_valid) n_rsp++;
    if (!p_init && (afe_tx_en || afe_rx_en)) en_viol++;
    p_sen = afe_sen; p_clk = afe_spi_clk; p_init = init_done;
  end

  task automatic bring_up(input bit with_req);
    int hi, lo, t, r0;
    logic [FB-1:0] f;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    frames.delete();
    r0 = n_rsp;
    @(negedge clk);
    start = 1;
    if (with_req) begin
      req_valid = 1; req_rw = 0; req_addr = 7'h44; req_wdata = 8'h99;
      #1 chk("req_ready_with_start", req_ready, 0);
    end
    @(negedge clk);
    start = 0; req_valid = 0;
    chk("init_drop", init_done, 0);
    chk("busy_bringup", busy, 1);
    hi = 0;
    while (afe_reset && hi < RC + 10) begin hi++; @(negedge clk); end
    chk("afe_reset_len", hi, RC);
    lo = 0;
    while (afe_sen && !afe_reset && lo < WC + 10) begin lo++; @(negedge clk); end
    chk("wake_len", lo, WC);
    t = 0;
    while (!init_done && t < 2000) begin @(negedge clk); t++; end
    chk("init_done", init_done, 1);
    chk("en_lag", {afe_tx_en, afe_rx_en}, 2'b00);
    @(negedge clk);
    chk("en_after_init", {afe_tx_en, afe_rx_en}, {tx_en_req, rx_en_req});
    chk("busy_idle", busy, 0);
    chk("init_frames", frames.size(), IL);
    if (frames.size() == IL) begin
      f = frames.pop_front(); chk("init_frame0", f, 16'h05A5);
      f = frames.pop_front(); chk("init_frame1", f, 16'h7F3C);
    end
    chk("no_rsp_in_init", n_rsp, r0);
    ref_mem[7'h05] = 8'hA5;
    ref_mem[7'h7F] = 8'h3C;
  endtask

  task automatic xfer(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int t;
    logic [FB-1:0] f, ef;
    @(negedge clk);
    req_valid = 1; req_rw = rw; req_addr = addr; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    chk("req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0;
    req_rw = 1'($urandom); req_addr = 7'($urandom); req_wdata = 8'($urandom);
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 400) begin @(negedge clk); t++; end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_lat", cyc - fall_cyc, (2*FB + 1)*DIV);
    ef = {rw, addr, rw ? 8'h00 : wd};
    chk("xfer_frames", frames.size(), 1);
    if (frames.size() > 0) begin
      f = frames.pop_front();
      chk("xfer_frame", f, ef);
    end
    if (rw) chk("rdata", rsp_rdata, ref_mem[addr]);
    else ref_mem[addr] = wd;
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin : wdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, t, r0;
    for (int i = 0; i < 128; i++) begin
      afe_mem[i] = 8'($urandom);
      ref_mem[i] = afe_mem[i];
    end
    afe_mem[7'h33] = 8'hC3; ref_mem[7'h33] = 8'hC3;

    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_sen", afe_sen, 1);
    chk("rst_outs", {afe_reset, afe_spi_clk, afe_spi_mosi, afe_tx_en, afe_rx_en,
                     init_done, busy, req_ready, rsp_valid}, 9'd0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_tbl_idx", tbl_idx, 0);
    reset = 0;
    tx_en_req = 1; rx_en_req = 1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!afe_sen || afe_spi_clk || afe_spi_mosi || afe_reset || busy || init_done ||
          rsp_valid || req_ready || afe_tx_en || afe_rx_en || tbl_idx != 0) bad++;
    end
    chk("off_quiet", bad, 0);

    bring_up(0);
    xfer(0, 7'h12, 8'h5A);
    xfer(1, 7'h33, 8'h77);
    xfer(1, 7'h05, 8'h00);

    for (int n = 0; n < 24; n++) begin
      xfer(1'($urandom), 7'($urandom_range(0, 15)), 8'($urandom));
      if (n % 6 == 5) begin
        @(negedge clk);
        tx_en_req = 1'($urandom); rx_en_req = 1'($urandom);
        @(negedge clk);
        chk("en_follow", {afe_tx_en, afe_rx_en}, {tx_en_req, rx_en_req});
        tx_en_req = 1; rx_en_req = 1;
        @(negedge clk);
      end
    end

    // start collides with a request in IDLE: bring-up again, no access
    bring_up(1);
    xfer(1, 7'h44, 8'h00);

    // abort a read frame with asynchronous reset
    @(negedge clk);
    req_valid = 1; req_rw = 1; req_addr = 7'h33;
    t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    @(posedge clk);
    #1 req_valid = 0;
    frames.delete();
    r0 = n_rsp;
    repeat (40) @(negedge clk);
    chk("abort_mid_frame", afe_sen, 0);
    #2 reset = 1;
    #1;
    chk("abort_sen", afe_sen, 1);
    chk("abort_sclk", afe_spi_clk, 0);
    chk("abort_init", init_done, 0);
    repeat (5) @(negedge clk);
    chk("abort_no_rsp", n_rsp, r0);
    chk("abort_no_frame", frames.size(), 0);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("abort_off", {busy, afe_reset, afe_tx_en, afe_rx_en}, 4'd0);
    bring_up(0);
    xfer(1, 7'h7F, 8'h00);
    xfer(1, 7'h33, 8'h00);

    chk("sclk_timing", sclk_viol, 0);
    chk("en_forced_off", en_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
